// File: rtl/if_stage_bpred.sv
// Instruction-fetch stage: PC register, instruction-memory address and a direct-mapped BTB predictor.
// Define BPRED_EN to build the BTB; without it the stage fetches sequentially and honours redirects only.
module if_stage_bpred #(
  parameter int          BTB_IDX_W = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        JumpPredictF,
  output logic [31:0] PredTargetF,
  input  logic        RedirectE,
  input  logic [31:0] RedirectPCE,
  input  logic        ResolveValidE,
  input  logic [31:0] ResolvePCE,
  input  logic        ResolveTakenE,
  input  logic [31:0] ResolveTargetE
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        jump_predict;
  logic [31:0] pred_target;

  assign pc_plus4     = pc_q + 32'd4;
  assign PCF          = pc_q;
  assign ImemAddr     = pc_q;
  assign InstrF       = ImemRdata;
  assign PCPlus4F     = pc_plus4;
  assign JumpPredictF = jump_predict;
  assign PredTargetF  = pred_target;

`ifdef BPRED_EN
  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W       = 32 - BTB_IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [31:0]            tgt_q [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];

  logic [BTB_IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]     tag_f, tag_e;
  logic                 hit_f, hit_e;
  logic [1:0]           unused_resolve_lsb;

  assign idx_f = pc_q[BTB_IDX_W+1:2];
  assign tag_f = pc_q[31:BTB_IDX_W+2];
  assign idx_e = ResolvePCE[BTB_IDX_W+1:2];
  assign tag_e = ResolvePCE[31:BTB_IDX_W+2];
  assign unused_resolve_lsb = ResolvePCE[1:0];

  // Lookup reads registered state, so a same-cycle update only shows up next cycle.
  assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign jump_predict = hit_f && ctr_q[idx_f][1];
  assign pred_target  = hit_f ? tgt_q[idx_f] : 32'h0;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (ResolveValidE && ResolveTakenE && !hit_e) begin
      valid_q[idx_e] <= 1'b1;
    end
  end

  // NOTE: tag/target/counter storage is deliberately not reset; valid_q gates every use of it.
  always_ff @(posedge clk) begin
    if (ResolveValidE) begin
      if (hit_e) begin
        if (ResolveTakenE) begin
          if (ctr_q[idx_e] != 2'b11) ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
          tgt_q[idx_e] <= ResolveTargetE;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
        end
      end else if (ResolveTakenE) begin
        tag_q[idx_e] <= tag_e;
        tgt_q[idx_e] <= ResolveTargetE;
        ctr_q[idx_e] <= 2'b10;
      end
    end
  end
`else
  logic unused_resolve;

  assign jump_predict   = 1'b0;
  assign pred_target    = 32'h0;
  assign unused_resolve = ^{ResolveValidE, ResolvePCE, ResolveTakenE, ResolveTargetE};
`endif

  // NOTE: pc_d takes a default before the priority chain so no latch can be inferred.
  always_comb begin
    pc_d = pc_q;
    if (RedirectE)         pc_d = RedirectPCE;
    else if (StallF)       pc_d = pc_q;
    else if (jump_predict) pc_d = pred_target;
    else                   pc_d = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_if_stage_bpred.sv
// Scoreboard bench for if_stage_bpred: directed cycles push expected fetch outputs, a negedge monitor pops and compares.
// Expectations follow whichever BPRED_EN build is compiled.
module tb_if_stage_bpred;

`ifdef BPRED_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        jp;
    logic [31:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0;
  logic [31:0] ImemAddr, ImemRdata, InstrF, PCF, PCPlus4F, PredTargetF;
  logic        JumpPredictF;
  logic        RedirectE = 1'b0;
  logic [31:0] RedirectPCE = '0;
  logic        ResolveValidE = 1'b0;
  logic [31:0] ResolvePCE = '0;
  logic        ResolveTakenE = 1'b0;
  logic [31:0] ResolveTargetE = '0;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory: the word is a fixed scramble of its address.
  assign ImemRdata = ImemAddr ^ 32'hDEAD_BEEF;

  if_stage_bpred #(.BTB_IDX_W(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF),
    .ImemAddr(ImemAddr), .ImemRdata(ImemRdata), .InstrF(InstrF),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .JumpPredictF(JumpPredictF), .PredTargetF(PredTargetF),
    .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
    .ResolveValidE(ResolveValidE), .ResolvePCE(ResolvePCE),
    .ResolveTakenE(ResolveTakenE), .ResolveTargetE(ResolveTargetE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: fetch outputs are presented every cycle; sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("PCF", PCF, e.pc);
        check("ImemAddr", ImemAddr, e.pc);
        check("PCPlus4F", PCPlus4F, e.pc + 32'd4);
        check("InstrF", InstrF, e.pc ^ 32'hDEAD_BEEF);
        check("JumpPredictF", {31'd0, JumpPredictF}, {31'd0, e.jp});
        check("PredTargetF", PredTargetF, e.tgt);
      end
    end
  end

  // One cycle of stimulus; expectation describes outputs during this cycle.
  task automatic cyc(input logic rst, input logic stall, input logic redir, input logic [31:0] rpc,
                     input logic rv, input logic [31:0] rvpc, input logic rt, input logic [31:0] rtgt,
                     input logic [31:0] epc, input logic ejp, input logic [31:0] etgt);
    exp_t e;
    rst_n          = ~rst;
    StallF         = stall;
    RedirectE      = redir;
    RedirectPCE    = rpc;
    ResolveValidE  = rv;
    ResolvePCE     = rvpc;
    ResolveTakenE  = rt;
    ResolveTargetE = rtgt;
    e.pc = epc; e.jp = ejp; e.tgt = etgt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] T100 = BP ? 32'h100 : 32'h0;
  localparam logic [31:0] T180 = BP ? 32'h180 : 32'h0;
  localparam logic [31:0] T800 = BP ? 32'h800 : 32'h0;

  initial begin
    int budget;
    @(posedge clk);
    #1;
    // Reset, then sequential fetch.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'hC, 0, 0);
    // Stall holds; redirect overrides stall.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
    cyc(0, 1, 1, 32'h200, 0, 0, 0, 0, 32'h10, 0, 0);
    cyc(0, 0, 1, 32'h40, 0, 0, 0, 0, 32'h200, 0, 0);
    // Allocate 0x40 while fetching it: old contents seen this cycle.
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 1, 32'h100, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, BP, T100);
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 0, 0, BP ? 32'h100 : 32'h44, 0, 0);
    // Counter hysteresis and saturation at both ends.
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 1, 32'h100, 32'h40, 0, T100);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'h40, 1, 32'h40, 1, 32'h100, 32'h40, BP, T100);
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 0, 0, 32'h40, BP, T100);
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 0, 0, 32'h40, BP, T100);
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 0, 0, 32'h40, 0, T100);
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 0, 0, 32'h40, 0, T100);
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 1, 32'h100, 32'h40, 0, T100);
    cyc(0, 0, 1, 32'h40, 1, 32'h40, 1, 32'h180, 32'h40, 0, T100);
    // Taken hit retargets the entry and prediction steers the PC.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, BP, T180);
    cyc(0, 0, 1, 32'h440, 0, 0, 0, 0, BP ? 32'h180 : 32'h44, 0, 0);
    // Tag alias at the same index.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h440, 0, 0);
    cyc(0, 0, 1, 32'h40, 1, 32'h440, 1, 32'h800, 32'h444, 0, 0);
    cyc(0, 0, 1, 32'h440, 0, 0, 0, 0, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h440, BP, T800);
    cyc(0, 0, 1, 32'h440, 1, 32'h40, 0, 0, BP ? 32'h800 : 32'h444, 0, 0);
    // Stall beats prediction.
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 32'h440, BP, T800);
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 32'h440, BP, T800);
    // 32-bit wrap.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    // Asynchronous reset mid-run clears PC and the BTB.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(0, 0, 1, 32'h440, 0, 0, 0, 0, 32'h0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h440, 0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      #1;
      budget++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage_bpred.md
Name: if_stage_bpred

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It holds the program counter and drives the instruction-memory address. It predicts taken jumps and branches with a direct-mapped branch target buffer (BTB) that uses 2-bit saturating counters. It produces InstrF, PCPlus4F, JumpPredictF and PCF for the IF/ID register, and accepts redirect and training information from the execute stage.

Parameters:
BTB_IDX_W, 4, log2 of BTB entry count (16 entries)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
StallF  input  1  hazard unit: hold PC
ImemAddr  output  32  instruction memory address, equal to PCF
ImemRdata  input  32  instruction word, combinational read of ImemAddr
InstrF  output  32  fetched instruction, equal to ImemRdata
PCF  output  32  current fetch PC
PCPlus4F  output  32  PCF + 4
JumpPredictF  output  1  BTB predicts taken for PCF
PredTargetF  output  32  predicted target; valid when JumpPredictF=1
RedirectE  input  1  execute-stage mispredict; load RedirectPCE
RedirectPCE  input  32  correct next PC
ResolveValidE  input  1  a control-transfer instruction resolved in execute this cycle
ResolvePCE  input  32  PC of the resolved instruction
ResolveTakenE  input  1  actual outcome
ResolveTargetE  input  32  actual target

Behaviour:
- Reset, asynchronous, active-low:
  - PCF = RESET_PC.
  - All BTB valid bits = 0, so JumpPredictF = 0 and PredTargetF = 0 out of reset.
  - Counter and target storage need no reset.
- BTB entry: valid, tag = PC[31:BTB_IDX_W+2], target[31:0], ctr[1:0]. Index = PC[BTB_IDX_W+1:2].
- Lookup is combinational on PCF:
  - hit = valid & tag match.
  - JumpPredictF = hit & ctr[1].
  - PredTargetF = target on hit, else 0.
- Next-PC priority, registered on the clock edge:
  1. RedirectE → RedirectPCE. Overrides StallF.
  2. StallF → PCF held.
  3. JumpPredictF → PredTargetF.
  4. Otherwise → PCF + 4, with 32-bit wrap (32'hFFFF_FFFC + 4 = 0).
- PCPlus4F is always PCF + 4, regardless of prediction.
- Training on a clock edge with ResolveValidE=1, indexed and tagged by ResolvePCE:
  - Hit and taken: ctr saturating increment (max 3); target ← ResolveTargetE.
  - Hit and not taken: ctr saturating decrement (min 0). The entry stays valid.
  - Miss and taken: allocate (overwrite the slot); valid=1, tag, target, ctr=2'b10 (weakly taken).
  - Miss and not taken: no change.
- Training is independent of StallF and RedirectE.
- Same-cycle lookup and update of the same index: lookup sees the old contents; the new contents are visible from the next cycle.
- Single write port; one update per cycle maximum.
- Reset asserted mid-operation: PC and valid bits clear immediately, regardless of clk.
- Latency: PCF changes one clock after a redirect; a trained entry affects prediction one clock after the update edge.

Optional Feature:
BPRED_EN
- Defined: the BTB is instantiated and operates as above.
- Undefined:
  - No BTB storage is instantiated.
  - JumpPredictF = 0 and PredTargetF = 0 constantly.
  - Next PC = RedirectPCE on RedirectE, hold on StallF, else PCF + 4.
  - Resolve inputs are ignored.

Test Plan:
- Reset then run: release rst_n with RESET_PC=0, no stall → PCF = 0, 4, 8, 12 on successive cycles; JumpPredictF=0 throughout.
- Stall vs redirect: PCF=0x10, StallF=1 for 3 cycles → PCF stays 0x10. Then StallF=1 with RedirectE=1, RedirectPCE=0x200 → next PCF=0x200.
- BTB allocation: ResolveValidE, ResolvePCE=0x40, Taken=1, Target=0x100. Then fetch 0x40 → JumpPredictF=1, PredTargetF=0x100, next PCF=0x100, PCPlus4F=0x44.
- Counter hysteresis: from ctr=2 at 0x40, resolve not-taken once → ctr=1, prediction 0. Resolve taken twice → ctr=3. Three further taken → ctr stays 3.
- Tag alias: 0x40 allocated; fetch 0x440 (same index, different tag) → miss, next PCF=0x444. Resolve 0x440 taken to 0x800 → entry replaced; 0x40 now misses.
- Same-cycle hazard: PCF=0x40 while allocating 0x40 → JumpPredictF=0 that cycle. On revisit → 1. With BPRED_EN undefined, the same stimulus → JumpPredictF always 0.
